// File: rtl/button_debounce_edge_pkg.sv
// Shared constants for the button conditioning blocks. Debounce lengths are
// derived from the board clock so that callers can state them in microseconds.
package button_debounce_edge_pkg;

    localparam int CLK_FREQ_HZ = 12_000_000;

    function automatic int cycles_from_us(input int us);
        return (CLK_FREQ_HZ / 1_000_000) * us;
    endfunction

    // 1 ms settle time
    localparam int DEBOUNCE_CYCLES_DEF = cycles_from_us(1000);

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchroniser for external asynchronous inputs, reset to 0.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/button_debounce_edge.sv
// Push-button conditioner: synchronise, debounce with a stability counter, and
// emit a clean level, one-cycle rise/fall pulses and a press toggle.
module button_debounce_edge
    import button_debounce_edge_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES),
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_rise,
    output logic btn_fall,
    output logic btn_toggle
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 d_in;
    logic                 s2;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 arm_q, arm_d;
    logic                 level_q, level_d;
    logic                 rise_q, rise_d;
    logic                 fall_q, fall_d;
    logic                 tog_q, tog_d;

    assign d_in = btn_raw ^ ACTIVE_LOW;

    sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (d_in),
        .q   (s2)
    );

    // The first mismatching edge only arms the counter, so a new level must be
    // seen on DEBOUNCE_CYCLES+1 consecutive edges before it is accepted.
    always_comb begin
        cnt_d   = cnt_q;
        arm_d   = arm_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        tog_d   = tog_q;
        if (s2 == level_q) begin
            cnt_d = '0;
            arm_d = 1'b0;
        end else if (!arm_q) begin
            arm_d = 1'b1;
        end else if (cnt_q == CNT_MAX) begin
            level_d = s2;
            cnt_d   = '0;
            arm_d   = 1'b0;
            rise_d  = s2;
            fall_d  = ~s2;
            tog_d   = tog_q ^ s2;
        end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            arm_q   <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            tog_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            arm_q   <= arm_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            tog_q   <= tog_d;
        end
    end

    assign btn_level  = level_q;
    assign btn_rise   = rise_q;
    assign btn_fall   = fall_q;
    assign btn_toggle = tog_q;

endmodule

// File: tb/tb_button_debounce_edge.sv
// Bench for button_debounce_edge: one active-high and one active-low instance,
// checked every cycle against a stability-window model through a scoreboard.
module tb_button_debounce_edge;

    localparam int D = 4;

    typedef struct {
        int         n;
        logic [3:0] v0;
        logic [3:0] v1;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic raw0 = 1'b0;
    logic raw1 = 1'b1;
    logic lvl0, rise0, fall0, tog0;
    logic lvl1, rise1, fall1, tog1;

    int checks = 0;
    int failures = 0;
    exp_t sbq[$];

    // model state, index 0 = active-high DUT, 1 = active-low DUT
    logic [7:0] hist[2];
    logic       mlvl[2];
    logic       mtog[2];
    int         edge_n = 0;
    logic       prev_rs = 1'b1;
    int         last_rise[2] = '{-100, -100};
    int         last_fall[2] = '{-100, -100};
    int         k;

    always #5 clk = ~clk;

    button_debounce_edge #(.DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .btn_raw(raw0),
        .btn_level(lvl0), .btn_rise(rise0), .btn_fall(fall0), .btn_toggle(tog0)
    );

    button_debounce_edge #(.DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .btn_raw(raw1),
        .btn_level(lvl1), .btn_rise(rise1), .btn_fall(fall1), .btn_toggle(tog1)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [3:0] model_edge(input int i, input logic d, input logic rs);
        logic [D:0] w;
        logic r, f;
        if (rs) begin
            hist[i] = '0;
            mlvl[i] = 1'b0;
            mtog[i] = 1'b0;
            return 4'b0000;
        end
        hist[i] = {hist[i][6:0], d};
        w = hist[i][D+2:2];
        r = 1'b0;
        f = 1'b0;
        if (!mlvl[i] && (&w)) begin
            mlvl[i] = 1'b1;
            r = 1'b1;
            mtog[i] = ~mtog[i];
        end else if (mlvl[i] && !(|w)) begin
            mlvl[i] = 1'b0;
            f = 1'b1;
        end
        return {mlvl[i], r, f, mtog[i]};
    endfunction

    // One clock edge: drive inputs mid-low-phase, then push the expectation.
    task automatic step(input logic a, input logic b, input logic rs);
        exp_t e;
        @(negedge clk);
        #1;
        raw0 = a;
        raw1 = b;
        rst  = rs;
        if (rs && !prev_rs) begin
            #1;
            chk("rst_async0", {28'd0, lvl0, rise0, fall0, tog0}, 32'd0);
            chk("rst_async1", {28'd0, lvl1, rise1, fall1, tog1}, 32'd0);
        end
        prev_rs = rs;
        @(posedge clk);
        edge_n++;
        e.n  = edge_n;
        e.v0 = model_edge(0, a, rs);
        e.v1 = model_edge(1, ~b, rs);
        sbq.push_back(e);
    endtask

    task automatic hold(input logic a, input logic b, input int n);
        for (int i = 0; i < n; i++) step(a, b, 1'b0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("out0", {28'd0, lvl0, rise0, fall0, tog0}, {28'd0, e.v0});
            chk("out1", {28'd0, lvl1, rise1, fall1, tog1}, {28'd0, e.v1});
            if (rise0) last_rise[0] = e.n;
            if (fall0) last_fall[0] = e.n;
            if (rise1) last_rise[1] = e.n;
            if (fall1) last_fall[1] = e.n;
        end
    end

    initial begin
        hist[0] = '0; hist[1] = '0;
        mlvl[0] = 1'b0; mlvl[1] = 1'b0;
        mtog[0] = 1'b0; mtog[1] = 1'b0;

        // reset held while the pin chatters
        for (int i = 0; i < 10; i++) step(1'($urandom_range(0, 1)), 1'b1, 1'b1);
        hold(1'b0, 1'b1, 20);

        // clean press
        step(1'b1, 1'b1, 1'b0);
        k = edge_n;
        hold(1'b1, 1'b1, 9);
        chk("press_lat", 32'(last_rise[0] - k), 32'd6);
        chk("press_nofall", 32'(last_fall[0]), 32'hffffff9c);
        hold(1'b0, 1'b1, 10);

        // bounce 1,0,1,1,0,1 then held
        step(1'b1, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
        k = edge_n;
        hold(1'b1, 1'b1, 10);
        chk("bounce_lat", 32'(last_rise[0] - k), 32'd6);

        // release / press sequence, ending pressed
        hold(1'b0, 1'b1, 10);
        hold(1'b1, 1'b1, 10);
        hold(1'b0, 1'b1, 10);
        hold(1'b1, 1'b1, 10);
        chk("level_before_rst", {31'd0, lvl0}, 32'd1);

        // reset while the level is high, then reset in the middle of a count
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        hold(1'b0, 1'b1, 10);
        hold(1'b1, 1'b1, 4);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        k = edge_n;
        hold(1'b1, 1'b1, 10);
        chk("rst_mid_lat", 32'(last_rise[0] - k), 32'd6);

        // active-low instance: press then release
        step(1'b1, 1'b0, 1'b0);
        k = edge_n;
        hold(1'b1, 1'b0, 10);
        chk("al_rise_lat", 32'(last_rise[1] - k), 32'd6);
        step(1'b1, 1'b1, 1'b0);
        k = edge_n;
        hold(1'b1, 1'b1, 10);
        chk("al_fall_lat", 32'(last_fall[1] - k), 32'd6);

        @(negedge clk);
        #1;
        chk("sb_drain", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
